// File: rtl/devil_ac_frontend_if.sv
// AC snoop channel and devil-core snoop queue handshake bundle.
// master drives AC requests and consumes the queue; slave is the frontend.
interface devil_ac_frontend_if #(
    parameter int ADDR_W  = 44,
    parameter int SNOOP_W = 4
);
    logic               acvalid;
    logic               acready;
    logic [ADDR_W-1:0]  acaddr;
    logic [SNOOP_W-1:0] acsnoop;
    logic               snp_valid;
    logic               snp_ready;
    logic [ADDR_W-1:0]  snp_addr;
    logic [SNOOP_W-1:0] snp_snoop;
    logic               snp_hit;

    modport master (
        output acvalid,
        output acaddr,
        output acsnoop,
        input  acready,
        input  snp_valid,
        input  snp_addr,
        input  snp_snoop,
        input  snp_hit,
        output snp_ready
    );

    modport slave (
        input  acvalid,
        input  acaddr,
        input  acsnoop,
        output acready,
        output snp_valid,
        output snp_addr,
        output snp_snoop,
        output snp_hit,
        input  snp_ready
    );
endinterface

// File: rtl/devil_ac_frontend.sv
// ACE AC snoop frontend: filters snoops into hit/miss tags and queues
// them in a small circular FIFO for the devil core, with hit/miss counters.
module devil_ac_frontend #(
    parameter int ADDR_W  = 44,
    parameter int SNOOP_W = 4,
    parameter int DEPTH   = 4
) (
    input  logic                       clk_100MHz,
    input  logic                       reset,
    input  logic                       acvalid,
    output logic                       acready,
    input  logic [ADDR_W-1:0]          acaddr,
    input  logic [SNOOP_W-1:0]         acsnoop,
    input  logic                       en,
    input  logic                       acflt_en,
    input  logic                       addrflt_en,
    input  logic [SNOOP_W-1:0]         cfg_acsnoop,
    input  logic [31:0]                cfg_base,
    input  logic [31:0]                cfg_size,
    input  logic                       clr_cnt,
    output logic                       snp_valid,
    input  logic                       snp_ready,
    output logic [ADDR_W-1:0]          snp_addr,
    output logic [SNOOP_W-1:0]         snp_snoop,
    output logic                       snp_hit,
    output logic [15:0]                hit_cnt,
    output logic [15:0]                miss_cnt,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;
    localparam int AW1 = ADDR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [SNOOP_W-1:0] snoop;
        logic               hit;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   lvl;
    logic [LW-1:0]   lvl_nxt;
    logic            rdy_q;
    logic            push;
    logic            pop;
    logic            hit;
    logic            in_range;
    logic            type_ok;
    logic            addr_ok;
    logic [AW1-1:0]  base_x;
    logic [AW1-1:0]  end_x;
    logic [AW1-1:0]  addr_x;
    entry_t          head;

    assign push = acvalid & rdy_q;
    assign pop  = snp_valid & snp_ready;

    // One extra bit on the range end so base+size never wraps.
    assign base_x   = AW1'(cfg_base);
    assign end_x    = base_x + AW1'(cfg_size);
    assign addr_x   = {1'b0, acaddr};
    assign in_range = (cfg_size != 32'd0)
                    && (addr_x >= base_x)
                    && (addr_x < end_x);

    assign type_ok = !acflt_en || (acsnoop == cfg_acsnoop);
    assign addr_ok = !addrflt_en || in_range;
    assign hit     = en && type_ok && addr_ok;

    always_comb begin
        lvl_nxt = lvl;
        unique case ({push, pop})
            2'b10:   lvl_nxt = lvl + LW'(1);
            2'b01:   lvl_nxt = lvl - LW'(1);
            default: lvl_nxt = lvl;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
            rdy_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            lvl   <= lvl_nxt;
            rdy_q <= (lvl_nxt != LW'(DEPTH));
        end
    end

    // Storage needs no reset; stale entries are hidden by the pointers.
    always_ff @(posedge clk_100MHz) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: acaddr, snoop: acsnoop, hit: hit};
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (clr_cnt) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (push) begin
            if (hit && hit_cnt != 16'hFFFF) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (!hit && miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

    assign head      = mem[rd_ptr];
    assign snp_valid = (lvl != '0);
    assign snp_addr  = snp_valid ? head.addr : '0;
    assign snp_snoop = snp_valid ? head.snoop : '0;
    assign snp_hit   = snp_valid ? head.hit : 1'b0;
    assign acready   = rdy_q;
    assign level     = lvl;
endmodule

// File: tb/tb_devil_ac_frontend.sv
// Directed bench for devil_ac_frontend: filter vector table plus
// hand-written backpressure, wrap, reset and counter sequences.
module tb_devil_ac_frontend;
    logic        clk;
    logic        reset;
    logic        en;
    logic        acflt_en;
    logic        addrflt_en;
    logic [3:0]  cfg_acsnoop;
    logic [31:0] cfg_base;
    logic [31:0] cfg_size;
    logic        clr_cnt;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    logic [2:0]  level;
    int          checks;
    int          errors;

    devil_ac_frontend_if #(.ADDR_W(44), .SNOOP_W(4)) bus ();

    devil_ac_frontend #(.ADDR_W(44), .SNOOP_W(4), .DEPTH(4)) dut (
        .clk_100MHz  (clk),
        .reset       (reset),
        .acvalid     (bus.acvalid),
        .acready     (bus.acready),
        .acaddr      (bus.acaddr),
        .acsnoop     (bus.acsnoop),
        .en          (en),
        .acflt_en    (acflt_en),
        .addrflt_en  (addrflt_en),
        .cfg_acsnoop (cfg_acsnoop),
        .cfg_base    (cfg_base),
        .cfg_size    (cfg_size),
        .clr_cnt     (clr_cnt),
        .snp_valid   (bus.snp_valid),
        .snp_ready   (bus.snp_ready),
        .snp_addr    (bus.snp_addr),
        .snp_snoop   (bus.snp_snoop),
        .snp_hit     (bus.snp_hit),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt),
        .level       (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [43:0] addr;
        logic [3:0]  snoop;
        logic        en;
        logic        acflt;
        logic        addrflt;
        logic [3:0]  csnoop;
        logic [31:0] base;
        logic [31:0] size;
        logic        hit;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        reset = 1'b0;
        en = 1'b0;
        acflt_en = 1'b0;
        addrflt_en = 1'b0;
        cfg_acsnoop = 4'h0;
        cfg_base = 32'h0;
        cfg_size = 32'h0;
        clr_cnt = 1'b0;
        bus.acvalid = 1'b0;
        bus.acaddr = 44'h0;
        bus.acsnoop = 4'h0;
        bus.snp_ready = 1'b0;

        vecs[0]  = '{44'h10,        4'h0, 1'b1, 1'b0, 1'b1, 4'h0,
                     32'h10,        32'h100, 1'b1};
        vecs[1]  = '{44'h10F,       4'h0, 1'b1, 1'b0, 1'b1, 4'h0,
                     32'h10,        32'h100, 1'b1};
        vecs[2]  = '{44'h110,       4'h0, 1'b1, 1'b0, 1'b1, 4'h0,
                     32'h10,        32'h100, 1'b0};
        vecs[3]  = '{44'h0F,        4'h0, 1'b1, 1'b0, 1'b1, 4'h0,
                     32'h10,        32'h100, 1'b0};
        vecs[4]  = '{44'h20,        4'h1, 1'b1, 1'b1, 1'b0, 4'h1,
                     32'h0,         32'h0,   1'b1};
        vecs[5]  = '{44'h24,        4'h0, 1'b1, 1'b1, 1'b0, 4'h1,
                     32'h0,         32'h0,   1'b0};
        vecs[6]  = '{44'h28,        4'h1, 1'b0, 1'b1, 1'b0, 4'h1,
                     32'h0,         32'h0,   1'b0};
        vecs[7]  = '{44'h10,        4'h0, 1'b1, 1'b0, 1'b1, 4'h0,
                     32'h10,        32'h0,   1'b0};
        vecs[8]  = '{44'h5,         4'h3, 1'b1, 1'b0, 1'b0, 4'h0,
                     32'h0,         32'h0,   1'b1};
        vecs[9]  = '{44'h1_0000_0000, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0,
                     32'hFFFF_FF00, 32'h200, 1'b1};
        vecs[10] = '{44'h1_0000_0100, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0,
                     32'hFFFF_FF00, 32'h200, 1'b0};
        vecs[11] = '{44'h100F,      4'h7, 1'b1, 1'b1, 1'b1, 4'h7,
                     32'h1000,      32'h10,  1'b1};

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst_level", 64'(level), 64'd0);
        check("rst_acready", 64'(bus.acready), 64'd0);
        check("rst_valid", 64'(bus.snp_valid), 64'd0);
        check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        check("rst_addr", 64'(bus.snp_addr), 64'd0);
        step();
        reset = 1'b0;
        check("rel_acready_lo", 64'(bus.acready), 64'd0);
        step();
        check("rel_acready_hi", 64'(bus.acready), 64'd1);

        // Filter table
        for (int i = 0; i < 12; i++) begin
            en = vecs[i].en;
            acflt_en = vecs[i].acflt;
            addrflt_en = vecs[i].addrflt;
            cfg_acsnoop = vecs[i].csnoop;
            cfg_base = vecs[i].base;
            cfg_size = vecs[i].size;
            bus.acaddr = vecs[i].addr;
            bus.acsnoop = vecs[i].snoop;
            bus.acvalid = 1'b1;
            step();
            bus.acvalid = 1'b0;
            check($sformatf("vec%0d_valid", i),
                  64'(bus.snp_valid), 64'd1);
            check($sformatf("vec%0d_hit", i),
                  64'(bus.snp_hit), 64'(vecs[i].hit));
            check($sformatf("vec%0d_addr", i),
                  64'(bus.snp_addr), 64'(vecs[i].addr));
            check($sformatf("vec%0d_snoop", i),
                  64'(bus.snp_snoop), 64'(vecs[i].snoop));
            bus.snp_ready = 1'b1;
            step();
            bus.snp_ready = 1'b0;
            check($sformatf("vec%0d_drain", i), 64'(level), 64'd0);
        end
        check("tbl_hit_cnt", 64'(hit_cnt), 64'd6);
        check("tbl_miss_cnt", 64'(miss_cnt), 64'd6);

        en = 1'b1;
        acflt_en = 1'b0;
        addrflt_en = 1'b0;

        // Backpressure to full, then one pop and wrap-around drain
        n = 0;
        bus.acvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (!bus.acready) break;
            bus.acaddr = 44'h100 + 44'(n);
            step();
            n++;
        end
        bus.acvalid = 1'b0;
        check("bp_pushes", 64'(n), 64'd4);
        check("bp_level", 64'(level), 64'd4);
        check("bp_acready", 64'(bus.acready), 64'd0);
        check("bp_head", 64'(bus.snp_addr), 64'h100);
        bus.snp_ready = 1'b1;
        check("bp_pop_cycle_rdy", 64'(bus.acready), 64'd0);
        step();
        bus.snp_ready = 1'b0;
        check("bp_after_pop_rdy", 64'(bus.acready), 64'd1);
        check("bp_after_pop_lvl", 64'(level), 64'd3);
        bus.acaddr = 44'h104;
        bus.acvalid = 1'b1;
        step();
        bus.acvalid = 1'b0;
        check("wrap_level", 64'(level), 64'd4);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("wrap_order%0d", k),
                  64'(bus.snp_addr), 64'h100 + 64'(k));
            bus.snp_ready = 1'b1;
            step();
            bus.snp_ready = 1'b0;
        end
        check("wrap_empty", 64'(bus.snp_valid), 64'd0);
        check("wrap_empty_addr", 64'(bus.snp_addr), 64'd0);

        // Simultaneous push and pop at level 2
        bus.acvalid = 1'b1;
        bus.acaddr = 44'h200;
        step();
        bus.acaddr = 44'h201;
        step();
        check("sim_level0", 64'(level), 64'd2);
        bus.snp_ready = 1'b1;
        bus.acaddr = 44'h202;
        step();
        check("sim_level1", 64'(level), 64'd2);
        check("sim_head1", 64'(bus.snp_addr), 64'h201);
        bus.acaddr = 44'h203;
        step();
        check("sim_level2", 64'(level), 64'd2);
        check("sim_head2", 64'(bus.snp_addr), 64'h202);
        bus.acvalid = 1'b0;
        step();
        check("sim_head3", 64'(bus.snp_addr), 64'h203);
        step();
        bus.snp_ready = 1'b0;
        check("sim_empty", 64'(level), 64'd0);

        // One-cycle latency into an empty queue
        bus.acaddr = 44'h300;
        bus.acvalid = 1'b1;
        check("lat_no_bypass", 64'(bus.snp_valid), 64'd0);
        step();
        check("lat_valid", 64'(bus.snp_valid), 64'd1);
        check("lat_addr", 64'(bus.snp_addr), 64'h300);

        // Reset with three entries queued
        bus.acaddr = 44'h301;
        step();
        bus.acaddr = 44'h302;
        step();
        bus.acvalid = 1'b0;
        check("mid_level3", 64'(level), 64'd3);
        #2 reset = 1'b1;
        #1;
        check("mid_level", 64'(level), 64'd0);
        check("mid_valid", 64'(bus.snp_valid), 64'd0);
        check("mid_hit_cnt", 64'(hit_cnt), 64'd0);
        check("mid_miss_cnt", 64'(miss_cnt), 64'd0);
        check("mid_acready", 64'(bus.acready), 64'd0);
        step();
        reset = 1'b0;
        check("mid_rel_lo", 64'(bus.acready), 64'd0);
        step();
        check("mid_rel_hi", 64'(bus.acready), 64'd1);

        // Hit counter saturation
        en = 1'b1;
        bus.acaddr = 44'h400;
        bus.acvalid = 1'b1;
        bus.snp_ready = 1'b1;
        repeat (65537) step();
        bus.acvalid = 1'b0;
        step();
        bus.snp_ready = 1'b0;
        check("sat_hit_cnt", 64'(hit_cnt), 64'hFFFF);
        check("sat_miss_cnt", 64'(miss_cnt), 64'd0);
        check("sat_level", 64'(level), 64'd0);

        // Clear coincident with a miss push
        en = 1'b0;
        clr_cnt = 1'b1;
        bus.acvalid = 1'b1;
        step();
        clr_cnt = 1'b0;
        bus.acvalid = 1'b0;
        check("clr_hit_cnt", 64'(hit_cnt), 64'd0);
        check("clr_miss_cnt", 64'(miss_cnt), 64'd0);
        check("clr_queued", 64'(level), 64'd1);
        check("clr_entry_miss", 64'(bus.snp_hit), 64'd0);
        en = 1'b1;
        bus.acvalid = 1'b1;
        step();
        bus.acvalid = 1'b0;
        check("post_clr_hit", 64'(hit_cnt), 64'd1);
        check("post_clr_miss", 64'(miss_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/devil_ac_frontend.md
DEVIL_AC_FRONTEND -- requirements
Module: devil_ac_frontend

Interface
REQ-001 SHALL have parameter ADDR_W, default 44, width of AC snoop address.
REQ-002 SHALL have parameter SNOOP_W, default 4, width of AC snoop type.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries (power of two, at least 2).
REQ-004 SHALL have port clk_100MHz  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port acvalid  in  1  ACE AC channel request valid.
REQ-007 SHALL have port acready  out  1  AC channel ready.
REQ-008 SHALL have port acaddr  in  ADDR_W  snoop address.
REQ-009 SHALL have port acsnoop  in  SNOOP_W  snoop transaction type.
REQ-010 SHALL have port en  in  1  trojan enable (CTRL.EN).
REQ-011 SHALL have port acflt_en  in  1  snoop-type filter enable (CTRL.ACFLT).
REQ-012 SHALL have port addrflt_en  in  1  address-range filter enable (CTRL.ADDRFLT).
REQ-013 SHALL have port cfg_acsnoop  in  SNOOP_W  snoop type to match (ACSNOOP reg).
REQ-014 SHALL have port cfg_base  in  32  range base (BASE_ADDR reg).
REQ-015 SHALL have port cfg_size  in  32  range size in bytes (MEM_SIZE reg).
REQ-016 SHALL have port clr_cnt  in  1  single-cycle pulse clearing counters.
REQ-017 SHALL have port snp_valid  out  1  queued snoop available to the devil core.
REQ-018 SHALL have port snp_ready  in  1  devil core accepts head entry.
REQ-019 SHALL have port snp_addr  out  ADDR_W  head entry address.
REQ-020 SHALL have port snp_snoop  out  SNOOP_W  head entry snoop type.
REQ-021 SHALL have port snp_hit  out  1  head entry matched filters (core manipulates only hits).
REQ-022 SHALL have port hit_cnt  out  16  accepted snoops tagged hit.
REQ-023 SHALL have port miss_cnt  out  16  accepted snoops tagged miss.
REQ-024 SHALL have port level  out  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-025 SHALL accept an AC request (push) in any cycle where acvalid and acready are both 1.
REQ-026 SHALL drive acready = (level < DEPTH), derived only from registered occupancy; never depends on acvalid.
REQ-027 SHALL compute hit at push = en AND (NOT acflt_en OR acsnoop == cfg_acsnoop) AND (NOT addrflt_en OR in_range), using config values of the push cycle.
REQ-028 SHALL compute in_range = (acaddr >= zero-extended cfg_base) AND (acaddr < cfg_base + cfg_size), with the sum evaluated at ADDR_W+1 bits; no wrap.
REQ-029 SHALL treat cfg_size = 0 as an empty range: in_range = 0.
REQ-030 SHALL tag every snoop as miss when en = 0 but still queue it, so snoop traffic never stalls on the enable.
REQ-031 SHALL store {acaddr, acsnoop, hit} in a DEPTH-entry circular FIFO; write/read pointers wrap from DEPTH-1 to 0.
REQ-032 SHALL drive snp_valid = (level != 0); snp_addr/snp_snoop/snp_hit show the head entry, stable while snp_valid is 1 and snp_ready is 0.
REQ-033 SHALL pop the head when snp_valid and snp_ready are both 1.
REQ-034 SHALL provide a latency of exactly 1 cycle: a push at edge N makes snp_valid 1 after edge N if the queue was empty; no combinational bypass.
REQ-035 SHALL handle a simultaneous push and pop with level unchanged and both pointers advancing.
REQ-036 SHALL, when full, assert acready = 0; a pop in that cycle raises acready in the next cycle only.
REQ-037 SHALL increment hit_cnt or miss_cnt by 1 at each push according to the tag; each saturates at 16'hFFFF.
REQ-038 SHALL, on clr_cnt, zero both counters; clear wins over a same-cycle increment.

Reset
REQ-039 SHALL on reset assertion immediately clear pointers, level=0, hit_cnt=0, miss_cnt=0, snp_valid=0, acready=0; queued entries are discarded, including mid-operation.
REQ-040 SHALL drive acready=1 from the first rising edge after reset deassertion; snp_addr/snp_snoop/snp_hit are 0 while empty after reset.

Verification
REQ-041 Filter hit: en=1, addrflt_en=1, cfg_base=0x10, cfg_size=0x100; acaddr 0x10, 0x10F, 0x110, 0x0F -> snp_hit 1,1,0,0; hit_cnt=2, miss_cnt=2.
REQ-042 Snoop filter: en=1, acflt_en=1, cfg_acsnoop=1; acsnoop 1 then 0 -> snp_hit 1 then 0; en=0 with acsnoop=1 -> snp_hit 0.
REQ-043 Backpressure: snp_ready=0, acvalid held 1 -> acready drops after 4 pushes (DEPTH=4), level=4; one pop -> acready=1 the next cycle; order of entries preserved, FIFO order checked through wrap-around.
REQ-044 Simultaneous push/pop at level=2 -> level stays 2 and output order preserved; push into empty queue -> snp_valid high exactly 1 cycle later.
REQ-045 Reset mid-operation with level=3 -> level=0, snp_valid=0, counters 0 immediately; acready=1 after first edge post-deassertion.
REQ-046 Counters: force 65537 hit pushes -> hit_cnt=0xFFFF; clr_cnt coincident with a push -> both counters read 0.
